// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: IF request/response, LS request/response and
// the shared memory bus. The arbiter connects through the slave modport; the
// environment (fetch unit, load/store unit and bus model) uses the master modport.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    // Instruction fetch port
    logic              if_req_valid_i;
    logic              if_req_ready_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_rsp_valid_o;
    logic              if_rsp_ready_i;
    logic [DATA_W-1:0] if_rsp_data_o;

    // Load/store port
    logic              ls_req_valid_i;
    logic              ls_req_ready_o;
    logic [ADDR_W-1:0] ls_addr_i;
    logic              ls_wen_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic [MASK_W-1:0] ls_mask_i;
    logic              ls_rsp_valid_o;
    logic              ls_rsp_ready_i;
    logic [DATA_W-1:0] ls_rsp_data_o;

    // Memory bus
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wen_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [MASK_W-1:0] mem_mask_o;
    logic              mem_rsp_valid_i;
    logic              mem_rsp_ready_o;
    logic [DATA_W-1:0] mem_rsp_data_i;

    modport slave (
        input  if_req_valid_i, if_addr_i, if_rsp_ready_i,
        input  ls_req_valid_i, ls_addr_i, ls_wen_i, ls_wdata_i, ls_mask_i, ls_rsp_ready_i,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
        output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o,
        output mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_mask_o,
        output mem_rsp_ready_o
    );

    modport master (
        output if_req_valid_i, if_addr_i, if_rsp_ready_i,
        output ls_req_valid_i, ls_addr_i, ls_wen_i, ls_wdata_i, ls_mask_i, ls_rsp_ready_i,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
        input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o,
        input  mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_mask_o,
        input  mem_rsp_ready_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store.
// One transaction at a time: IDLE accepts, REQ drives the bus, RESP captures data,
// RET hands the response back to its owner. LS wins by default; after STARVE_MAX
// consecutive LS grants with IF waiting, IF is forced through.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    bus,
    output logic [1:0]           owner_o
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_MAX);

    localparam logic [1:0] OwnNone = 2'b00;
    localparam logic [1:0] OwnIf   = 2'b01;
    localparam logic [1:0] OwnLs   = 2'b10;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StRet} state_e;

    state_e            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic sel_ls, sel_if;

    // Requester selection; only meaningful in IDLE, where it drives the req readies.
    always_comb begin
        sel_ls = bus.ls_req_valid_i && (!bus.if_req_valid_i || (starve_q < CntMax));
        sel_if = bus.if_req_valid_i && !sel_ls;
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        rsp_data_d = rsp_data_q;
        starve_d   = starve_q;

        bus.if_req_ready_o  = 1'b0;
        bus.ls_req_ready_o  = 1'b0;
        bus.if_rsp_valid_o  = 1'b0;
        bus.ls_rsp_valid_o  = 1'b0;
        bus.mem_req_valid_o = 1'b0;
        bus.mem_rsp_ready_o = 1'b0;

        // Latched fields drive the bus and response data continuously; only the
        // valid strobes qualify them.
        bus.mem_addr_o    = addr_q;
        bus.mem_wen_o     = wen_q;
        bus.mem_wdata_o   = wdata_q;
        bus.mem_mask_o    = mask_q;
        bus.if_rsp_data_o = rsp_data_q;
        bus.ls_rsp_data_o = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                bus.ls_req_ready_o = sel_ls;
                bus.if_req_ready_o = sel_if;
                if (sel_ls) begin
                    addr_d  = bus.ls_addr_i;
                    wen_d   = bus.ls_wen_i;
                    wdata_d = bus.ls_wdata_i;
                    mask_d  = bus.ls_mask_i;
                    owner_d = OwnLs;
                    state_d = StReq;
                    // Only count LS grants that made a waiting IF lose.
                    if (bus.if_req_valid_i && (starve_q != CntMax)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (sel_if) begin
                    addr_d   = bus.if_addr_i;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    mask_d   = {MASK_W{1'b1}};
                    owner_d  = OwnIf;
                    state_d  = StReq;
                    starve_d = '0;
                end
            end
            StReq: begin
                bus.mem_req_valid_o = 1'b1;
                if (bus.mem_req_ready_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                bus.mem_rsp_ready_o = 1'b1;
                if (bus.mem_rsp_valid_i) begin
                    rsp_data_d = bus.mem_rsp_data_i;
                    state_d    = StRet;
                end
            end
            StRet: begin
                if (owner_q == OwnIf) begin
                    bus.if_rsp_valid_o = 1'b1;
                    if (bus.if_rsp_ready_i) begin
                        state_d = StIdle;
                        owner_d = OwnNone;
                    end
                end else if (owner_q == OwnLs) begin
                    bus.ls_rsp_valid_o = 1'b1;
                    if (bus.ls_rsp_ready_i) begin
                        state_d = StIdle;
                        owner_d = OwnNone;
                    end
                end else begin
                    // No owner cannot happen here; recover to IDLE.
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= OwnNone;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            rsp_data_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            rsp_data_q <= rsp_data_d;
            starve_q   <= starve_d;
        end
    end

    assign owner_o = owner_q;
endmodule
